// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared states, widths and polynomial constants for the ALU BIST controller.
package alu_bist_pkg;
    typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;
    localparam int PAT_W = 11;
    localparam int SIG_W = 5;
    localparam int CNT_W = 12;
    localparam int LFSR_TAP_A = 10;
    localparam int LFSR_TAP_B = 8;
    localparam logic [SIG_W-1:0] MISR_POLY = 5'b00101;
    function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] s);
        return {s[PAT_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction
endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if: operand/opcode/result link between the BIST controller (master) and the ALU (slave).
interface alu_bist_if;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_result;
    logic       alu_zero;
    modport master (output alu_a, alu_b, alu_opcode, input alu_result, alu_zero);
    modport slave (input alu_a, alu_b, alu_opcode, output alu_result, alu_zero);
endinterface

// File: rtl/alu_bist_misr.sv
// alu_bist_misr: 5-bit MISR over x^5+x^2+1; load takes priority over en.
module alu_bist_misr
    import alu_bist_pkg::*;
#(
    parameter logic [SIG_W-1:0] RESET_SIG = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [SIG_W-1:0] data_in,
    output logic [SIG_W-1:0] sig
);
    always_ff @(posedge clk or posedge rst)
        if (rst) sig <= RESET_SIG;
        else if (load) sig <= seed;
        else if (en) sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ data_in;
endmodule

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: LFSR-driven ALU self-test with MISR signature check.
// Define ALU_BIST_EXHAUSTIVE_EN to sweep all 2048 vectors with a binary counter instead.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int               NUM_PATTERNS = 255,
    parameter logic [PAT_W-1:0] LFSR_SEED    = 11'h001,
    parameter logic [SIG_W-1:0] MISR_SEED    = 5'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] golden_sig,
    alu_bist_if.master       alu,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);
    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] pat_next;
    logic [CNT_W-1:0] cnt;
    logic             launch;
    logic             last;
`ifdef ALU_BIST_EXHAUSTIVE_EN
    localparam logic [PAT_W-1:0] PAT_INIT = '0;
    assign pat_next = pat + 1'b1;
    assign last = pat == '1;
`else
    localparam logic [PAT_W-1:0] PAT_INIT = LFSR_SEED;
    assign pat_next = lfsr_step(pat);
    assign last = cnt == CNT_W'(NUM_PATTERNS - 1);
`endif
    assign launch = start && (state == IDLE || state == DONE);
    assign alu.alu_a = state == RUN ? pat[10:7] : '0;
    assign alu.alu_b = state == RUN ? pat[6:3] : '0;
    assign alu.alu_opcode = state == RUN ? pat[2:0] : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            pat <= PAT_INIT;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else if (launch) begin
            state <= RUN;
            pat <= PAT_INIT;
            cnt <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
        end else if (state == RUN) begin
            pat <= pat_next;
            cnt <= cnt + 1'b1;
            state <= last ? COMPARE : RUN;
        end else if (state == COMPARE) begin
            pass <= signature == golden_sig;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
        end
    alu_bist_misr #(.RESET_SIG(MISR_SEED)) u_misr (
        .clk     (clk),
        .rst     (rst),
        .load    (launch),
        .seed    (MISR_SEED),
        .en      (state == RUN),
        .data_in ({alu.alu_zero, alu.alu_result}),
        .sig     (signature)
    );
endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb_alu_bist_ctrl: scoreboard bench for alu_bist_ctrl with NUM_PATTERNS of 1, 2 and 255 side by side.
module tb_alu_bist_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = '0;
    logic [2:0]  fz = '0;
    logic [2:0]  busy, done, pass, dq = '0;
    logic [4:0]  golden [3];
    logic [4:0]  sig [3];
    logic [3:0]  a [3];
    logic [3:0]  b [3];
    logic [2:0]  op [3];
    logic [5:0]  q [3][$];
    logic [10:0] pv [3];
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    function automatic logic [3:0] alu_f(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
        case (o)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return ~x;
            3'd6: return x << 1;
            default: return x >> 1;
        endcase
    endfunction
    function automatic logic [4:0] model(input int n);
        logic [10:0] l = 11'h001;
        logic [10:0] p;
        logic [4:0]  m = 5'h00;
        logic [3:0]  r;
        for (int i = 0; i < n; i++) begin
`ifdef ALU_BIST_EXHAUSTIVE_EN
            p = i[10:0];
`else
            p = l;
`endif
            r = alu_f(p[10:7], p[6:3], p[2:0]);
            m = {m[3:0], 1'b0} ^ (m[4] ? 5'h05 : 5'h00) ^ {r == 4'h0, r};
            l = {l[9:0], l[10] ^ l[8]};
        end
        return m;
    endfunction
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NP = g == 0 ? 1 : g == 1 ? 2 : 255;
        alu_bist_if bus ();
        assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);
        assign bus.alu_zero = (bus.alu_result == 4'h0) & ~fz[g];
        assign a[g] = bus.alu_a;
        assign b[g] = bus.alu_b;
        assign op[g] = bus.alu_opcode;
        alu_bist_ctrl #(.NUM_PATTERNS(NP)) dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .golden_sig (golden[g]),
            .alu        (bus),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .signature  (sig[g])
        );
    end
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic rchk(input string n, input int g);
        check(n, {busy[g], done[g], pass[g], a[g], b[g], op[g], sig[g]}, 32'h0);
    endtask
    task automatic pulse(input int g);
        @(posedge clk);
        #1 start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
    endtask
    task automatic run(input int g, input int n, input logic [4:0] gold, input logic [5:0] exp,
                       input int fc, input int mid);
        int cyc = 0;
        int nb = 0;
        golden[g] = gold;
        q[g].push_back(exp);
        pulse(g);
        fz[g] = fc == 0;
        check("pass_clear", {30'h0, done[g], pass[g]}, 32'h0);
        while (!done[g] && cyc <= n + 5) begin
            if (busy[g]) nb++;
            if (cyc <= 2) check($sformatf("vec%0d_g%0d", cyc, g), {a[g], b[g], op[g]}, cyc < n ? pv[cyc] : 11'h0);
            @(posedge clk);
            #1 cyc++;
            fz[g] = cyc == fc;
            start[g] = cyc == mid;
        end
        fz[g] = 1'b0;
        start[g] = 1'b0;
        check($sformatf("done_latency_g%0d", g), cyc, n + 1);
        check($sformatf("busy_cycles_g%0d", g), nb, n + 1);
    endtask
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (done[g] && !dq[g]) begin
                if (q[g].size() == 0) check($sformatf("unexpected_done_g%0d", g), 1, 0);
                else check($sformatf("sig_pass_g%0d", g), {pass[g], sig[g]}, q[g].pop_front());
            end
            dq[g] <= done[g];
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [4:0] m;
`ifdef ALU_BIST_EXHAUSTIVE_EN
        pv[0] = 11'h000; pv[1] = 11'h001; pv[2] = 11'h002;
`else
        pv[0] = 11'h001; pv[1] = 11'h002; pv[2] = 11'h004;
`endif
        for (int g = 0; g < 3; g++) golden[g] = 5'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rchk($sformatf("reset_g%0d", g), g);
        rst = 1'b0;
        pulse(2);
        repeat (10) @(posedge clk);
        #1 check("busy_mid_run", {31'h0, busy[2]}, 32'h1);
        #2 rst = 1'b1;
        #1 rchk("reset_mid_run", 2);
        #2 rst = 1'b0;
`ifdef ALU_BIST_EXHAUSTIVE_EN
        m = model(2048);
        run(0, 2048, m, {1'b1, m}, -1, -1);
`else
        run(0, 1, 5'h10, 6'h30, -1, -1);
        run(1, 2, 5'h15, 6'h35, -1, -1);
        run(1, 2, 5'h15, 6'h05, 1, -1);
        m = model(255);
        run(2, 255, m, {1'b1, m}, -1, 100);
        run(2, 255, m, {1'b1, m}, -1, -1);
`endif
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) check($sformatf("queue_empty_g%0d", g), q[g].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
- Built-in self-test controller for the 4-bit ALU. It is the driving and observing end of the ALU's operand/opcode/result interface.
- An LFSR generates {A, B, opcode} stimulus. A MISR compacts {zero_flag, result} into a 5-bit signature, which is compared against a golden value.
- Sits beside the ALU in the DFT wrapper and is started and polled by the test access logic.

Parameters:
- NUM_PATTERNS, 255, number of vectors applied per run; legal range 1..2047.
- LFSR_SEED, 11'h001, LFSR load value at run start; must be nonzero.
- MISR_SEED, 5'h00, MISR load value at run start.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request, sampled in IDLE/DONE.
- golden_sig  input  5  expected signature, sampled on the COMPARE edge.
- alu_a  output  4  operand A to ALU.
- alu_b  output  4  operand B to ALU.
- alu_opcode  output  3  opcode to ALU.
- alu_result  input  4  ALU result (combinational response).
- alu_zero  input  1  ALU zero flag.
- busy  output  1  high in RUN and COMPARE.
- done  output  1  run complete; sticky until restart.
- pass  output  1  signature matched; valid while done=1.
- signature  output  5  current MISR contents.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, lfsr=LFSR_SEED, misr=MISR_SEED, cnt=0.
  - alu_a/alu_b/alu_opcode=0; busy=done=pass=0.
- FSM states: IDLE, RUN, COMPARE, DONE.
- IDLE or DONE, with start=1 at an edge:
  - lfsr<=LFSR_SEED, misr<=MISR_SEED, cnt<=0, done<=0, pass<=0.
  - Next state RUN.
- RUN, every edge:
  - misr absorbs {alu_zero, alu_result} for the pattern currently driven.
  - lfsr steps; cnt increments.
  - If cnt==NUM_PATTERNS-1, go to COMPARE.
- COMPARE, one edge: pass<=(misr==golden_sig), done<=1, then DONE.
- Stimulus mapping:
  - In RUN: alu_a=lfsr[10:7], alu_b=lfsr[6:3], alu_opcode=lfsr[2:0].
  - Outside RUN: all three are 0.
- LFSR: Fibonacci x^11+x^9+1, lfsr_next={lfsr[9:0], lfsr[10]^lfsr[8]}.
- MISR: x^5+x^2+1, misr_next={misr[3:0],1'b0} ^ (misr[4]?5'b00101:5'b0) ^ {alu_zero, alu_result}.
- Latency: start sampled at edge E0; done=1 after edge E0+NUM_PATTERNS+1; busy is high for NUM_PATTERNS+1 cycles.
- start during RUN/COMPARE is ignored.
- start in DONE restarts and clears done/pass on the same edge.
- rst mid-run aborts immediately to reset values; no partial result is retained.
- signature is updated every RUN edge and frozen in COMPARE/DONE/IDLE.
- cnt is 12 bits and never wraps within a run.

Optional Feature:
- Macro: ALU_BIST_EXHAUSTIVE_EN.
- Defined:
  - The LFSR is replaced by an 11-bit binary up-counter starting at 0.
  - Pattern count is fixed at 2048, including the all-zero vector; NUM_PATTERNS is ignored.
  - COMPARE is entered when the counter reaches 11'h7FF.
- Undefined: LFSR behaviour as above.
- MISR, FSM and ports are identical in both builds.

Decomposition:
- Package alu_bist_pkg: state enum, PAT_W=11, SIG_W=5, CNT_W=12, LFSR tap constants, MISR polynomial 5'b00101.
- One sub-module, alu_bist_misr: clk, rst, load, seed, en, data_in[4:0], sig[4:0].

Test Plan:
- Reset: assert rst mid-RUN (cycle 10) -> next sample shows state IDLE, busy=0, done=0, alu_* =0, signature=MISR_SEED.
- NUM_PATTERNS=1, seed 001, real ALU, golden 5'h10:
  - Pattern A=0, B=0, op=001 gives result=0, zero=1.
  - Required: signature=5'h10, pass=1, done at E0+2.
- NUM_PATTERNS=2, golden 5'h15:
  - Patterns lfsr 001 then 002 (op=010, result=0, zero=1).
  - Required: signature 5'h10 then 5'h15, pass=1.
- Fault: NUM_PATTERNS=2, golden 5'h15, alu_zero forced 0 -> signature 5'h05, pass=0, done=1.
- Default NUM_PATTERNS=255:
  - busy high exactly 256 cycles; done rises at E0+256.
  - A start pulse mid-run causes no restart.
  - A second start in DONE clears done and reruns with an identical signature.
- ALU_BIST_EXHAUSTIVE_EN build: first three vectors are {0,0,0}, {0,0,1}, {0,0,2}; done at E0+2049.
